controle_brinquedo: RTL
=======================

// Module: controle_brinquedo
// PURPOSE
//  Sequencer for the toy's timed ride cycle. The start button launches an 8-step countdown
//  (about 8 s at the default tick) that drives motor enable and the 3-bit value shown on the
//  7-segment decoder. An end signal follows the countdown. An emergency-stop button aborts
//  the cycle at any time. Sits between the board buttons and the seg* display decoders.
// PARAMETERS
//  TICK_DIV      50_000_000  clock cycles per countdown step (1 s at 50 MHz); >=2
//  DEBOUNCE_CYC  500_000     consecutive stable cycles needed to accept a button level; >=1
//  FIM_TICKS     2           steps that the end state (FIM) is held before returning to idle; >=1
// PORTS
//  clock_entrada  in   1  system clock, rising edge
//  reset_n        in   1  asynchronous active-low reset
//  botao          in   1  start button, raw, active-low (pressed = 0)
//  botao_parar    in   1  emergency-stop button, raw, active-low
//  contagem       out  3  countdown value for the display decoder (bit2 = MSB)
//  motor          out  1  motor enable; 1 only in CONTANDO
//  led_fim        out  1  end-of-ride indicator; 1 only in FIM
//  ocupado        out  1  1 in CONTANDO or FIM
// BEHAVIOUR
//  Reset, async on reset_n=0: state=OCIOSO, contagem=3'd0, motor=0, led_fim=0, ocupado=0,
//   prescaler=0, sync/debounce regs = released (1). No pulses are emitted on reset release.
//  Button path, identical for each button:
//   - 2-FF synchroniser, then a debounce counter.
//   - The debounced level updates after the synced input differs from it for DEBOUNCE_CYC
//     consecutive cycles; any bounce clears the counter.
//   - One-cycle press pulse (ini_p / par_p) on a 1->0 transition of the debounced level.
//   - Holding a button produces exactly one pulse.
//  Tick: prescaler runs only in CONTANDO and FIM; it is cleared on every state change.
//   tick=1 on the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0.
//   Prescaler width = $clog2(TICK_DIV).
//  FSM, registered outputs; all transitions take effect on the clock after the cause:
//   - OCIOSO: ini_p -> CONTANDO, contagem<=7.
//   - CONTANDO: on tick, if contagem!=0 then contagem<=contagem-1.
//     If contagem==0 on a tick -> FIM, fim_cnt<=0.
//     ini_p is ignored (no restart).
//   - FIM: contagem holds 0. On tick, fim_cnt++; when fim_cnt==FIM_TICKS-1 on a tick -> OCIOSO.
//     ini_p is ignored.
//   - Any state: par_p -> OCIOSO, contagem<=0, prescaler<=0.
//     If ini_p and par_p occur in the same cycle, par_p wins.
//  Countdown length: 8 ticks (values 7..0, each held TICK_DIV cycles) = 8*TICK_DIV cycles.
//  A reset during a cycle aborts it immediately (async); no state is retained.
//  Unused state encodings recover to OCIOSO.
// STRUCTURE
//  Package brinquedo_pkg: state localparams OCIOSO=2'd0, CONTANDO=2'd1, FIM=2'd2;
//   CONT_INICIAL=3'd7.
//  Sub-module detector_botao (synchroniser + debounce + press pulse, param DEBOUNCE_CYC),
//   instantiated twice.
//  Top holds the prescaler, FSM, contagem and fim_cnt.
// TESTING  (bench params: TICK_DIV=4, DEBOUNCE_CYC=2, FIM_TICKS=2)
//  1. Reset mid-run: assert reset_n=0 while contagem=5 -> outputs drop to 0/OCIOSO without
//     waiting for a clock edge.
//  2. Full ride: press botao, held low 10 cycles ->
//     - motor=1 and contagem=7 from the cycle after ini_p;
//     - contagem steps 7..0, one step per 4 cycles;
//     - after 32 cycles in CONTANDO: led_fim=1, motor=0, held 8 cycles;
//     - then ocupado=0.
//  3. Bounce: botao toggles 0/1 every cycle for 20 cycles, then stays 1 -> no ini_p; stays OCIOSO.
//  4. Emergency stop: press botao_parar at contagem=4 -> next cycle after par_p:
//     motor=0, contagem=0, OCIOSO; a later botao press restarts at 7.
//  5. Simultaneous: botao and botao_parar released->pressed on the same cycle in OCIOSO ->
//     remains OCIOSO.
//  6. Ignore restart: second botao press during CONTANDO and during FIM ->
//     contagem sequence and FIM duration unchanged.

Source files
------------

// File: rtl/brinquedo_pkg.sv
// Shared types and constants for the toy ride sequencer.
//  estado_t      : ride FSM state (OCIOSO idle, CONTANDO countdown, FIM end hold)
//  CONT_INICIAL  : first value shown when a ride starts
package brinquedo_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    FIM      = 2'd2
  } estado_t;

  localparam logic [2:0] CONT_INICIAL = 3'd7;

endpackage

// File: rtl/detector_botao.sv
// Raw active-low button -> one-cycle press pulse.
// 2-FF synchroniser, debounce counter, falling-edge detect on the debounced level.
// Ports:
//  clock_entrada  in  system clock, rising edge
//  reset_n        in  asynchronous active-low reset
//  botao_bruto    in  raw button level, pressed = 0
//  pulso          out one-cycle pulse on each accepted press
module detector_botao #(
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic clock_entrada,
  input  logic reset_n,
  input  logic botao_bruto,
  output logic pulso
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sinc1;
  logic          sinc2;
  logic          nivel;
  logic          nivel_ant;
  logic [CW-1:0] cnt;

  // All level registers reset to "released" so reset release never yields a pulse.
  always_ff @(posedge clock_entrada or negedge reset_n) begin
    if (!reset_n) begin
      sinc1     <= 1'b1;
      sinc2     <= 1'b1;
      nivel     <= 1'b1;
      nivel_ant <= 1'b1;
      cnt       <= '0;
    end else begin
      sinc1     <= botao_bruto;
      sinc2     <= sinc1;
      nivel_ant <= nivel;
      if (sinc2 != nivel) begin
        // DEBOUNCE_CYC consecutive differing cycles accept the new level
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          nivel <= sinc2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulso = nivel_ant & ~nivel;

endmodule

// File: rtl/controle_brinquedo.sv
// Ride-cycle sequencer: start button launches an 8-step countdown driving the motor
// and the display value, followed by an end-of-ride hold; stop button aborts anytime.
// Ports:
//  clock_entrada  in   system clock, rising edge
//  reset_n        in   asynchronous active-low reset
//  botao          in   start button, raw, active-low
//  botao_parar    in   emergency-stop button, raw, active-low
//  contagem       out  3-bit countdown value for the display decoder
//  motor          out  motor enable, high only while counting
//  led_fim        out  end-of-ride indicator, high only in the end hold
//  ocupado        out  high while counting or in the end hold
module controle_brinquedo
  import brinquedo_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned FIM_TICKS    = 2
) (
  input  logic       clock_entrada,
  input  logic       reset_n,
  input  logic       botao,
  input  logic       botao_parar,
  output logic [2:0] contagem,
  output logic       motor,
  output logic       led_fim,
  output logic       ocupado
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned FW = (FIM_TICKS > 1) ? $clog2(FIM_TICKS) : 1;

  estado_t       estado, estado_prox;
  logic [2:0]    contagem_prox;
  logic [PW-1:0] presc, presc_prox;
  logic [FW-1:0] fim_cnt, fim_cnt_prox;
  logic          tick;
  logic          ini_p;
  logic          par_p;

  detector_botao #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_det_ini (
    .clock_entrada (clock_entrada),
    .reset_n       (reset_n),
    .botao_bruto   (botao),
    .pulso         (ini_p)
  );

  detector_botao #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_det_par (
    .clock_entrada (clock_entrada),
    .reset_n       (reset_n),
    .botao_bruto   (botao_parar),
    .pulso         (par_p)
  );

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    estado_prox   = estado;
    contagem_prox = contagem;
    fim_cnt_prox  = fim_cnt;
    presc_prox    = '0;
    case (estado)
      OCIOSO: begin
        if (ini_p) begin
          estado_prox   = CONTANDO;
          contagem_prox = CONT_INICIAL;
        end
      end
      CONTANDO: begin
        presc_prox = tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (contagem != 3'd0) begin
            contagem_prox = contagem - 3'd1;
          end else begin
            estado_prox  = FIM;
            fim_cnt_prox = '0;
          end
        end
      end
      FIM: begin
        presc_prox    = tick ? '0 : presc + PW'(1);
        contagem_prox = 3'd0;
        if (tick) begin
          if (fim_cnt == FW'(FIM_TICKS - 1)) begin
            estado_prox = OCIOSO;
          end else begin
            fim_cnt_prox = fim_cnt + FW'(1);
          end
        end
      end
      default: begin
        estado_prox   = OCIOSO;
        contagem_prox = 3'd0;
      end
    endcase
    // Stop overrides everything, including a same-cycle start.
    if (par_p) begin
      estado_prox   = OCIOSO;
      contagem_prox = 3'd0;
    end
    if (estado_prox != estado) begin
      presc_prox = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clock_entrada or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= OCIOSO;
      contagem <= 3'd0;
      presc    <= '0;
      fim_cnt  <= '0;
      motor    <= 1'b0;
      led_fim  <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      estado   <= estado_prox;
      contagem <= contagem_prox;
      presc    <= presc_prox;
      fim_cnt  <= fim_cnt_prox;
      motor    <= (estado_prox == CONTANDO);
      led_fim  <= (estado_prox == FIM);
      ocupado  <= (estado_prox == CONTANDO) || (estado_prox == FIM);
    end
  end

endmodule
